// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC transmit channel.
package hdlc_pkg;

  // Transmitter sequencing states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_FLAG = 3'd1,
    DATA       = 3'd2,
    END_FLAG   = 3'd3,
    ABORT      = 3'd4
  } tx_state_e;

  // Frame delimiter, shifted LSB first: 0,1,1,1,1,1,1,0
  localparam logic [7:0] FLAG_PATTERN = 8'b0111_1110;

  // Abort sequence, shifted LSB first: 0 followed by seven 1s
  localparam logic [7:0] ABORT_PATTERN = 8'b1111_1110;

  // Consecutive data ones that force a stuffed zero
  localparam int ONES_RUN_DEFAULT = 5;

endpackage

// File: rtl/hdlc_tx_channel_if.sv
// Byte-side handshake and serial output of the HDLC transmit channel.
interface hdlc_tx_channel_if;

  logic       Tx_ValidFrame;
  logic       Tx_AbortFrame;
  logic       Tx_DataAvail;
  logic [7:0] Tx_Data;
  logic       Tx_RdBuff;
  logic       Tx_NewByte;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;
  logic       Tx;

  // Byte source / frame requester side
  modport master (
    output Tx_ValidFrame,
    output Tx_AbortFrame,
    output Tx_DataAvail,
    output Tx_Data,
    input  Tx_RdBuff,
    input  Tx_NewByte,
    input  Tx_Done,
    input  Tx_AbortedTrans,
    input  Tx
  );

  // Transmitter side
  modport slave (
    input  Tx_ValidFrame,
    input  Tx_AbortFrame,
    input  Tx_DataAvail,
    input  Tx_Data,
    output Tx_RdBuff,
    output Tx_NewByte,
    output Tx_Done,
    output Tx_AbortedTrans,
    output Tx
  );

endinterface

// File: rtl/hdlc_tx_zero_insert.sv
// Ones-run tracker for HDLC zero insertion. Counts consecutive 1 data bits
// while the channel is sending payload and raises stall once the run length
// is reached, telling the channel to emit a 0 instead of the next data bit.
module hdlc_tx_zero_insert
  import hdlc_pkg::*;
#(
  parameter int ONES_RUN = ONES_RUN_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  input  logic data_bit,
  output logic stall
);

  localparam int CW = $clog2(ONES_RUN + 1);

  logic [CW-1:0] ones_q;
  logic [CW-1:0] ones_d;

  assign stall = count_en && (ones_q == CW'(ONES_RUN));

  // Next run length: grows on a driven data 1, resets on any driven 0
  // (data or stuffed) and whenever the channel leaves payload.
  always_comb begin
    ones_d = '0;
    if (count_en && !clear && !stall && data_bit) begin
      ones_d = ones_q + 1'b1;
    end
  end

  // Run-length register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/hdlc_tx_channel.sv
// HDLC transmit channel: opening flag, bit-stuffed payload bytes read from a
// byte buffer, closing flag, and an abort sequence. The serial line is
// registered, so every bit decided in a cycle appears on Tx one cycle later;
// Tx_NewByte and Tx_Done are registered alongside so they line up with Tx.
module hdlc_tx_channel
  import hdlc_pkg::*;
#(
  parameter logic [7:0] FLAG     = FLAG_PATTERN,
  parameter int         ONES_RUN = ONES_RUN_DEFAULT
) (
  input logic              Clk,
  input logic              Rst,
  hdlc_tx_channel_if.slave tx_if
);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       new_byte_q, new_byte_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic       rd_buff;
  logic       boundary;
  logic       stall;
  logic       data_bit;
  logic       last_bit;
  logic       count_en;
  logic       leave_data;

  assign data_bit   = shift_q[bit_idx_q];
  assign last_bit   = (bit_idx_q == 3'd7);
  assign count_en   = (state_q == DATA);
  assign leave_data = (state_d != DATA);

  hdlc_tx_zero_insert #(
    .ONES_RUN(ONES_RUN)
  ) u_zero_insert (
    .clk      (clk_unused_guard(Clk)),
    .rst_n    (Rst),
    .count_en (count_en),
    .clear    (leave_data),
    .data_bit (data_bit),
    .stall    (stall)
  );

  function automatic logic clk_unused_guard(input logic c);
    return c;
  endfunction

  // Next-state, next serial bit and strobes for the current state
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    new_byte_d = 1'b0;
    done_d     = 1'b0;
    aborted_d  = aborted_q;
    rd_buff    = 1'b0;
    boundary   = 1'b0;
    case (state_q)
      IDLE: begin
        bit_idx_d = '0;
        if (tx_if.Tx_ValidFrame) begin
          state_d   = START_FLAG;
          aborted_d = 1'b0;
        end
      end
      START_FLAG: begin
        tx_d = FLAG[bit_idx_q];
        if (tx_if.Tx_AbortFrame) begin
          state_d   = ABORT;
          bit_idx_d = '0;
          aborted_d = 1'b1;
        end else if (last_bit) begin
          boundary = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      DATA: begin
        tx_d       = stall ? 1'b0 : data_bit;
        new_byte_d = (bit_idx_q == 3'd0) && !stall;
        if (tx_if.Tx_AbortFrame) begin
          state_d   = ABORT;
          bit_idx_d = '0;
          shift_d   = '0;
          aborted_d = 1'b1;
        end else if (!stall) begin
          if (last_bit) begin
            boundary = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      END_FLAG: begin
        tx_d = FLAG[bit_idx_q];
        if (last_bit) begin
          state_d   = IDLE;
          bit_idx_d = '0;
          done_d    = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ABORT: begin
        tx_d = ABORT_PATTERN[bit_idx_q];
        if (last_bit) begin
          state_d   = IDLE;
          bit_idx_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_idx_d = '0;
      end
    endcase

    if (boundary) begin
      bit_idx_d = '0;
      if (tx_if.Tx_DataAvail) begin
        rd_buff = 1'b1;
        shift_d = tx_if.Tx_Data;
        state_d = DATA;
      end else begin
        state_d = END_FLAG;
      end
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      new_byte_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      new_byte_q <= new_byte_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign tx_if.Tx              = tx_q;
  assign tx_if.Tx_RdBuff       = rd_buff;
  assign tx_if.Tx_NewByte      = new_byte_q;
  assign tx_if.Tx_Done         = done_q;
  assign tx_if.Tx_AbortedTrans = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// Directed bench for hdlc_tx_channel: every serial bit is logged on the
// falling edge and whole frames are compared against hand-written bit strings.
module tb_hdlc_tx_channel;

  logic Clk = 1'b0;
  logic Rst;

  hdlc_tx_channel_if bus ();

  hdlc_tx_channel #(
    .FLAG     (8'b0111_1110),
    .ONES_RUN (5)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .tx_if (bus)
  );

  // 100 MHz-style free-running clock
  always #5 Clk = ~Clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic tx_log[$];
  int   nb_pos[$];
  int   rd_seen   = 0;
  int   nb_seen   = 0;
  int   done_seen = 0;

  logic [7:0] byte_list [4];
  int         byte_n    = 0;
  int         byte_base = 0;

  localparam string F = "01111110";

  // Log the serial line and count strobes away from the rising edge
  always @(negedge Clk) begin
    if (bus.Tx_NewByte === 1'b1) begin
      nb_pos.push_back(tx_log.size());
      nb_seen++;
    end
    if (bus.Tx_RdBuff === 1'b1) rd_seen++;
    if (bus.Tx_Done === 1'b1) done_seen++;
    tx_log.push_back(bus.Tx);
  end

  // Byte buffer model: presents the next unread byte, advances on Tx_RdBuff
  initial begin : data_driver
    int idx;
    forever begin
      idx = rd_seen - byte_base;
      if (idx >= 0 && idx < byte_n && idx < 4) begin
        bus.Tx_DataAvail = 1'b1;
        bus.Tx_Data      = byte_list[idx];
      end else begin
        bus.Tx_DataAvail = 1'b0;
        bus.Tx_Data      = 8'h00;
      end
      @(posedge Clk);
      #1;
    end
  end

  // Hard stop in case something never finishes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_cnt++;
    if (actual !== expected) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  function automatic logic [63:0] bits_of(input string s);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v[i] = (s[i] == "1");
    return v;
  endfunction

  // Frame starts at the first 0 after start; bit i of the result is log bit i
  task automatic checkFrame(input string tag, input int start, input string exp,
                            output int first);
    logic [63:0] got;
    first = -1;
    for (int i = start; i < tx_log.size(); i++) begin
      if (tx_log[i] === 1'b0) begin
        first = i;
        break;
      end
    end
    got = '0;
    if (first >= 0) begin
      for (int i = 0; i < exp.len() && first + i < tx_log.size(); i++) begin
        got[i] = tx_log[first + i];
      end
    end
    checkOutput(tag, got, bits_of(exp));
  endtask

  // Load up to two bytes, request one frame, optionally abort at a given edge
  task automatic applyStimulus(input int n, input logic [7:0] b0, input logic [7:0] b1,
                               input int abort_edge, output int log_start);
    int d0;
    byte_list[0] = b0;
    byte_list[1] = b1;
    byte_list[2] = 8'h00;
    byte_list[3] = 8'h00;
    byte_base    = rd_seen;
    byte_n       = n;
    step(1);
    log_start = tx_log.size();
    d0 = done_seen;
    bus.Tx_ValidFrame = 1'b1;
    step(1);
    bus.Tx_ValidFrame = 1'b0;
    if (abort_edge > 0) begin
      step(abort_edge - 1);
      bus.Tx_AbortFrame = 1'b1;
      step(1);
      bus.Tx_AbortFrame = 1'b0;
      step(12);
    end else begin
      for (int c = 0; c < 200 && done_seen == d0; c++) step(1);
      step(3);
    end
  endtask

  initial begin : stimulus
    int ls, first, rd0, nb0, d0, zeros;

    Rst               = 1'b0;
    bus.Tx_ValidFrame = 1'b0;
    bus.Tx_AbortFrame = 1'b0;

    // Reset state and quiet idle line
    step(2);
    checkOutput("reset_outputs",
                {bus.Tx, bus.Tx_RdBuff, bus.Tx_NewByte, bus.Tx_Done, bus.Tx_AbortedTrans},
                5'b10000);
    Rst = 1'b1;
    ls = tx_log.size(); rd0 = rd_seen; nb0 = nb_seen; d0 = done_seen;
    step(20);
    zeros = 0;
    for (int i = ls; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) zeros++;
    checkOutput("idle_zeros", zeros, 0);
    checkOutput("idle_strobes", {rd_seen - rd0, nb_seen - nb0, done_seen - d0}, 96'd0);

    // Single 0x00 byte
    rd0 = rd_seen; nb0 = nb_seen; d0 = done_seen;
    applyStimulus(1, 8'h00, 8'h00, 0, ls);
    checkFrame("frame_00", ls, {F, "00000000", F, "1"}, first);
    checkOutput("frame_00_rd", rd_seen - rd0, 1);
    checkOutput("frame_00_nb", nb_seen - nb0, 1);
    checkOutput("frame_00_done", done_seen - d0, 1);

    // Single 0xFF byte: one stuffed zero
    d0 = done_seen;
    applyStimulus(1, 8'hFF, 8'h00, 0, ls);
    checkFrame("frame_ff", ls, {F, "111110111", F, "1"}, first);
    checkOutput("frame_ff_done", done_seen - d0, 1);

    // 0x3E, 0x0F: stuffing inside the first byte only
    rd0 = rd_seen; nb0 = nb_seen;
    applyStimulus(2, 8'h3E, 8'h0F, 0, ls);
    checkFrame("frame_3e0f", ls, {F, "01111100011110000", F, "1"}, first);
    checkOutput("frame_3e0f_rd", rd_seen - rd0, 2);
    checkOutput("frame_3e0f_nb", nb_seen - nb0, 2);

    // 0xF0, 0xFF: ones run carried across the byte boundary
    applyStimulus(2, 8'hF0, 8'hFF, 0, ls);
    checkFrame("frame_f0ff", ls, {F, "00001111", "1011111011", F, "1"}, first);

    // 0xF8 alone: run of five ends at the flag, no stuffed zero
    applyStimulus(1, 8'hF8, 8'h00, 0, ls);
    checkFrame("frame_f8", ls, {F, "00011111", F, "1"}, first);

    // 0xF8, 0x00: stuffed zero leads the second byte, Tx_NewByte on its bit 0
    nb0 = nb_pos.size();
    applyStimulus(2, 8'hF8, 8'h00, 0, ls);
    checkFrame("frame_f800", ls, {F, "00011111", "0", "00000000", F, "1"}, first);
    checkOutput("f800_nb_count", nb_pos.size() - nb0, 2);
    if (nb_pos.size() - nb0 == 2) begin
      checkOutput("f800_nb_pos0", nb_pos[nb0] - first, 8);
      checkOutput("f800_nb_pos1", nb_pos[nb0 + 1] - first, 17);
    end

    // Abort sampled on the third bit of 0xA5
    rd0 = rd_seen; d0 = done_seen;
    applyStimulus(1, 8'hA5, 8'h00, 11, ls);
    checkFrame("frame_abort", ls, {F, "101", "01111111", "1"}, first);
    checkOutput("abort_flag", bus.Tx_AbortedTrans, 1);
    checkOutput("abort_no_done", done_seen - d0, 0);
    checkOutput("abort_rd", rd_seen - rd0, 1);
    step(10);
    checkOutput("abort_sticky", {bus.Tx_AbortedTrans, bus.Tx}, 2'b11);

    // Reset in the middle of a 0x00 byte, while bit 0 is on the line
    byte_list[0] = 8'h00;
    byte_base    = rd_seen;
    byte_n       = 1;
    step(1);
    bus.Tx_ValidFrame = 1'b1;
    step(1);
    bus.Tx_ValidFrame = 1'b0;
    step(1);
    checkOutput("abort_cleared", bus.Tx_AbortedTrans, 0);
    step(8);
    checkOutput("pre_reset_bit0", {bus.Tx, bus.Tx_NewByte}, 2'b01);
    #1;
    Rst = 1'b0;
    #1;
    checkOutput("mid_reset_outputs",
                {bus.Tx, bus.Tx_RdBuff, bus.Tx_NewByte, bus.Tx_Done, bus.Tx_AbortedTrans},
                5'b10000);
    step(2);
    Rst = 1'b1;
    ls = tx_log.size(); nb0 = nb_seen;
    step(6);
    zeros = 0;
    for (int i = ls; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) zeros++;
    checkOutput("post_reset_idle", zeros, 0);
    checkOutput("post_reset_nb", nb_seen - nb0, 0);

    // Fresh frame after reset
    d0 = done_seen;
    applyStimulus(1, 8'h00, 8'h00, 0, ls);
    checkFrame("frame_after_reset", ls, {F, "00000000", F, "1"}, first);
    checkOutput("after_reset_done", done_seen - d0, 1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
